// File: rtl/pwm_duty_ramp_if.sv
// Control/status bundle between a duty-ramp controller and pwm_duty_ramp.
//   target_duty : requested duty, 0.1 % units (values above 999 clamp to 999)
//   step_size   : duty increment per ramp step (0 behaves as 1)
//   breathe     : request continuous bounce between 0 and the target
//   load        : single-cycle strobe, latches the three fields above and starts a move
//   abort       : single-cycle strobe, freezes duty and returns to idle
//   duty        : current duty value fed to the PWM generator
//   busy        : high while a move or breathe cycle is in progress
//   done        : one-cycle pulse when a non-breathe move completes
interface pwm_duty_ramp_if;
    logic [9:0] target_duty;
    logic [4:0] step_size;
    logic       breathe;
    logic       load;
    logic       abort;
    logic [9:0] duty;
    logic       busy;
    logic       done;

    modport master (
        output target_duty, step_size, breathe, load, abort,
        input  duty, busy, done
    );

    modport slave (
        input  target_duty, step_size, breathe, load, abort,
        output duty, busy, done
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-cycle sequencer driving the 10-bit duty input of a 0.1 %-resolution
// PWM generator. Slews duty toward a latched target by step_size every
// STEP_DIV clocks (soft start/stop), or bounces between 0 and the target in
// breathe mode.
//   clk     : system clock
//   reset_p : synchronous, active-high reset
//   bus     : pwm_duty_ramp_if.slave (target_duty, step_size, breathe, load,
//             abort in; duty, busy, done out)
module pwm_duty_ramp #(
    parameter int STEP_DIV = 100_000
) (
    input  logic            clk,
    input  logic            reset_p,
    pwm_duty_ramp_if.slave  bus
);

    localparam int CNT_W = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    localparam logic [9:0] DUTY_MAX = 10'd999;

    // Saturate a requested target into the legal 0..999 duty range.
    function automatic logic [9:0] clamp_duty(input logic [9:0] v);
        return (v > DUTY_MAX) ? DUTY_MAX : v;
    endfunction

    // Upward step computed one bit wider so duty + 31 cannot wrap, then
    // saturated at the ceiling.
    function automatic logic [9:0] sat_step_up(input logic [9:0] d,
                                               input logic [4:0] s,
                                               input logic [9:0] ceil_v);
        logic [10:0] sum;
        sum = {1'b0, d} + {6'b0, s};
        return (sum >= {1'b0, ceil_v}) ? ceil_v : sum[9:0];
    endfunction

    // Downward step computed signed so a step past zero goes negative
    // rather than wrapping, then saturated at the floor.
    function automatic logic [9:0] sat_step_down(input logic [9:0] d,
                                                 input logic [4:0] s,
                                                 input logic [9:0] floor_v);
        logic signed [11:0] diff;
        diff = $signed({2'b00, d}) - $signed({7'b0, s});
        return (diff <= $signed({2'b00, floor_v})) ? floor_v : diff[9:0];
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [9:0]       duty_q,   duty_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [9:0]       tgt_q,    tgt_d;
    logic [4:0]       step_q,   step_d;
    logic             brth_q,   brth_d;
    logic [9:0]       floor_q,  floor_d;
    logic             done_q,   done_d;

    logic             tick;
    logic [9:0]       load_tgt;
    logic             load_brth;
    logic [9:0]       next_up;
    logic [9:0]       next_down;

    assign tick      = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    assign load_tgt  = clamp_duty(bus.target_duty);
    // A breathe request toward 0 has nothing to bounce between.
    assign load_brth = bus.breathe && (load_tgt != 10'd0);
    assign next_up   = sat_step_up(duty_q, step_q, tgt_q);
    assign next_down = sat_step_down(duty_q, step_q, floor_q);

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        brth_d  = brth_q;
        floor_d = floor_q;
        done_d  = 1'b0;
        cnt_d   = '0;
        if (state_q != ST_IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end

        if (bus.abort) begin
            state_d = ST_IDLE;
        end else if (bus.load) begin
            // Retarget: the step phase restarts and any coincident tick is dropped.
            tgt_d  = load_tgt;
            step_d = (bus.step_size == 5'd0) ? 5'd1 : bus.step_size;
            brth_d = load_brth;
            cnt_d  = '0;
            if (duty_q < load_tgt) begin
                state_d = ST_UP;
            end else if (duty_q > load_tgt) begin
                state_d = ST_DOWN;
                floor_d = load_brth ? 10'd0 : load_tgt;
            end else if (!load_brth) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_DOWN;
                floor_d = 10'd0;
            end
        end else if (tick) begin
            if (state_q == ST_UP) begin
                duty_d = next_up;
                if (next_up == tgt_q) begin
                    if (brth_q) begin
                        state_d = ST_DOWN;
                        floor_d = 10'd0;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end else if (state_q == ST_DOWN) begin
                duty_d = next_down;
                if (next_down == floor_q) begin
                    if (brth_q) begin
                        state_d = ST_UP;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        end

        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            duty_q  <= 10'd0;
            cnt_q   <= '0;
            tgt_q   <= 10'd0;
            step_q  <= 5'd1;
            brth_q  <= 1'b0;
            floor_q <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            brth_q  <= brth_d;
            floor_q <= floor_d;
            done_q  <= done_d;
        end
    end

    assign bus.duty = duty_q;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;

endmodule
